// File: rtl/mmtx_pkt_buf_pkg.sv
// Shared word layout, FSM state types and word helper for the mmtx transmit packet buffer.
package mmtx_pkt_buf_pkg;

  localparam int SOP_BIT  = 17;
  localparam int EOP_BIT  = 16;
  localparam int DATA_MSB = 15;
  localparam int WORD_W   = 18;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_PKT     = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_PKT  = 1'b1
  } rd_state_e;

  function automatic logic [WORD_W-1:0] pack_word(input logic sop, input logic eop,
                                                  input logic [DATA_MSB:0] data);
    return {sop, eop, data};
  endfunction

endpackage

// File: rtl/mmtx_pkt_buf_if.sv
// Writer-side and MAC-side signal bundle of the transmit packet buffer.
interface mmtx_pkt_buf_if #(
    parameter int ADDR_W = 9
);
    // Handshakes: a write word is taken on every clock where wr_dval=1 (no back-pressure per word;
    // the writer only opens a packet while wr_ready=1). A read is issued by mactx_mmtx_rdreq=1 while
    // mmtx_mactx_dval=0, and the word is presented with mmtx_mactx_dval=1 exactly one clock later.
    logic [15:0]     wr_data;
    logic            wr_sop;
    logic            wr_eop;
    logic            wr_dval;
    logic            wr_ready;
    logic            mactx_mmtx_rdreq;
    logic [17:0]     mmtx_mactx_data;
    logic            mmtx_mactx_dval;
    logic            pkt_drop;
    logic [ADDR_W:0] pkt_avail;

    modport master (
        output wr_data, wr_sop, wr_eop, wr_dval, mactx_mmtx_rdreq,
        input  wr_ready, mmtx_mactx_data, mmtx_mactx_dval, pkt_drop, pkt_avail
    );

    modport slave (
        input  wr_data, wr_sop, wr_eop, wr_dval, mactx_mmtx_rdreq,
        output wr_ready, mmtx_mactx_data, mmtx_mactx_dval, pkt_drop, pkt_avail
    );

endinterface

// File: rtl/mmtx_sdpram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port, no array reset.
module mmtx_sdpram #(
    parameter int WIDTH  = 18,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/mmtx_pkt_buf.sv
// Store-and-forward TX packet buffer: commits only complete packets, replays them to the MAC
// as {sop, eop, data} words, one word per MAC read request.
module mmtx_pkt_buf
    import mmtx_pkt_buf_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int MAX_PKT_W = 128
) (
    input  logic      clk_12_5m,
    input  logic      rst_12_5m,
    mmtx_pkt_buf_if.slave bus,
    output wr_state_e wr_state,
    output rd_state_e rd_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(MAX_PKT_W + 1);

    typedef logic [ADDR_W:0] ptr_t;

    ptr_t wr_ptr, cmt_ptr, rd_ptr, pkt_avail;
    ptr_t wr_ptr_nxt, cmt_ptr_nxt, wr_addr;
    ptr_t used_wr, used_cmt;
    logic [CNT_W-1:0] wcnt, wcnt_nxt;
    wr_state_e wr_state_nxt;
    rd_state_e rd_state_nxt;
    logic we, drop, commit, full_wr, full_cmt;
    logic readable, rd_en, dval, eop_out, wr_ready, pkt_drop;
    logic [WORD_W-1:0] ram_q, data_hold;

    assign used_wr  = wr_ptr - rd_ptr;
    assign used_cmt = cmt_ptr - rd_ptr;
    assign full_wr  = (used_wr == ptr_t'(DEPTH));
    assign full_cmt = (used_cmt == ptr_t'(DEPTH));

    // Write FSM. wr_ptr always equals cmt_ptr outside WR_PKT, so a new packet starts at cmt_ptr.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_ptr_nxt   = wr_ptr;
        cmt_ptr_nxt  = cmt_ptr;
        wcnt_nxt     = wcnt;
        wr_addr      = wr_ptr;
        we           = 1'b0;
        drop         = 1'b0;
        commit       = 1'b0;
        case (wr_state)
            WR_IDLE, WR_DISCARD: begin
                if (bus.wr_dval && bus.wr_sop) begin
                    if (bus.wr_eop) begin
                        drop         = 1'b1;
                        wr_state_nxt = WR_IDLE;
                    end else if (full_cmt) begin
                        drop         = 1'b1;
                        wr_state_nxt = WR_DISCARD;
                    end else begin
                        we           = 1'b1;
                        wr_addr      = cmt_ptr;
                        wr_ptr_nxt   = cmt_ptr + ptr_t'(1);
                        wcnt_nxt     = CNT_W'(1);
                        wr_state_nxt = WR_PKT;
                    end
                end else if (wr_state == WR_DISCARD && bus.wr_dval && bus.wr_eop) begin
                    wr_state_nxt = WR_IDLE;
                end
            end
            WR_PKT: begin
                if (bus.wr_dval) begin
                    if (bus.wr_sop) begin
                        // Restart: the open packet is abandoned and the new header lands at cmt_ptr.
                        drop       = 1'b1;
                        wr_ptr_nxt = cmt_ptr;
                        if (bus.wr_eop) begin
                            wr_state_nxt = WR_IDLE;
                        end else if (full_cmt) begin
                            wr_state_nxt = WR_DISCARD;
                        end else begin
                            we         = 1'b1;
                            wr_addr    = cmt_ptr;
                            wr_ptr_nxt = cmt_ptr + ptr_t'(1);
                            wcnt_nxt   = CNT_W'(1);
                        end
                    end else if (full_wr || (!bus.wr_eop && wcnt == CNT_W'(MAX_PKT_W - 1))) begin
                        drop         = 1'b1;
                        wr_ptr_nxt   = cmt_ptr;
                        wr_state_nxt = WR_DISCARD;
                    end else begin
                        we         = 1'b1;
                        wr_ptr_nxt = wr_ptr + ptr_t'(1);
                        wcnt_nxt   = wcnt + CNT_W'(1);
                        if (bus.wr_eop) begin
                            commit       = 1'b1;
                            cmt_ptr_nxt  = wr_ptr + ptr_t'(1);
                            wr_state_nxt = WR_IDLE;
                        end
                    end
                end
            end
            default: wr_state_nxt = WR_IDLE;
        endcase
    end

    // Read side: eop is only known when the word leaves the RAM, one clock after the read.
    assign readable = (rd_state == RD_PKT || pkt_avail != '0) && (rd_ptr != cmt_ptr);
    assign rd_en    = bus.mactx_mmtx_rdreq && !dval && readable;
    assign eop_out  = dval && ram_q[EOP_BIT];

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            RD_IDLE: if (rd_en) rd_state_nxt = RD_PKT;
            RD_PKT:  if (eop_out) rd_state_nxt = RD_IDLE;
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk_12_5m) begin
        if (rst_12_5m) begin
            wr_state  <= WR_IDLE;
            rd_state  <= RD_IDLE;
            wr_ptr    <= '0;
            cmt_ptr   <= '0;
            rd_ptr    <= '0;
            wcnt      <= '0;
            pkt_avail <= '0;
            dval      <= 1'b0;
            data_hold <= '0;
            pkt_drop  <= 1'b0;
            wr_ready  <= 1'b1;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            cmt_ptr  <= cmt_ptr_nxt;
            wcnt     <= wcnt_nxt;
            pkt_drop <= drop;
            dval     <= rd_en;
            if (rd_en) rd_ptr <= rd_ptr + ptr_t'(1);
            if (dval) data_hold <= ram_q;
            case ({commit, eop_out})
                2'b10:   pkt_avail <= pkt_avail + ptr_t'(1);
                2'b01:   pkt_avail <= pkt_avail - ptr_t'(1);
                default: pkt_avail <= pkt_avail;
            endcase
            wr_ready <= (int'(used_cmt) <= DEPTH - MAX_PKT_W);
        end
    end

    mmtx_sdpram #(
        .WIDTH (WORD_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk_12_5m),
        .we   (we),
        .waddr(wr_addr[ADDR_W-1:0]),
        .wdata(pack_word(bus.wr_sop, bus.wr_eop, bus.wr_data)),
        .re   (rd_en),
        .raddr(rd_ptr[ADDR_W-1:0]),
        .rdata(ram_q)
    );

    assign bus.mmtx_mactx_dval = dval;
    assign bus.mmtx_mactx_data = dval ? ram_q : data_hold;
    assign bus.pkt_drop        = pkt_drop;
    assign bus.pkt_avail       = pkt_avail;
    assign bus.wr_ready        = wr_ready;

endmodule
